// File: rtl/mem_resp_ctrl.sv
module mem_resp_ctrl #(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [63:0] address,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [63:0] wdata_mem,
  input  logic [7:0]  wmask_mem,
  output logic [63:0] rdata_mem,
  output logic        mem_rvalid,
  output logic        mem_busy,
  output logic        mem_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [7:0]       wmask_q, wmask_d;
  logic             we_q, we_d;
  logic             oob_q, oob_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             commit;
  logic             oob_w;
  logic             unused_addr;

  logic [63:0] mem_q [DEPTH];

`ifdef MEM_BOUND_CHECK_EN
  assign oob_w       = |address[63:3+IDX_W];
  assign unused_addr = ^address[2:0];
`else
  assign oob_w       = 1'b0;
  assign unused_addr = ^{address[2:0], address[63:3+IDX_W]};
`endif

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    we_d    = we_q;
    oob_d   = oob_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((re_mem || we_mem) && !flush) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
          idx_d   = address[3 +: IDX_W];
          wdata_d = wdata_mem;
          wmask_d = wmask_mem;
          we_d    = we_mem;
          oob_d   = oob_w;
        end
      end
      S_BUSY: begin
        // Commit is suppressed by flush and rst so an aborted request never touches the array.
        if (!flush && !rst) begin
          if (cnt_q == '0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (commit) rdata_d = oob_q ? '0 : mem_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      oob_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      we_q    <= we_d;
      oob_q   <= oob_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && we_q && !oob_q) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (wmask_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign rdata_mem  = rdata_q;
  assign mem_rvalid = (state_q == S_RESP);
  assign mem_busy   = (state_q != S_IDLE);
`ifdef MEM_BOUND_CHECK_EN
  assign mem_fault  = (state_q == S_RESP) && oob_q;
`else
  assign mem_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Randomised self-checking bench for mem_resp_ctrl against a word-array reference model.
module tb_mem_resp_ctrl;

    localparam int unsigned DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] address = '0;
    logic        re_mem = 1'b0;
    logic        we_mem = 1'b0;
    logic [63:0] wdata_mem = '0;
    logic [7:0]  wmask_mem = '0;
    logic [63:0] rdata_mem;
    logic        mem_rvalid;
    logic        mem_busy;
    logic        mem_fault;

    int checks = 0;
    int failures = 0;

    logic [63:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    mem_resp_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .address(address),
        .re_mem(re_mem), .we_mem(we_mem), .wdata_mem(wdata_mem), .wmask_mem(wmask_mem),
        .rdata_mem(rdata_mem), .mem_rvalid(mem_rvalid), .mem_busy(mem_busy), .mem_fault(mem_fault)
    );

    function automatic bit ref_oob(input logic [63:0] a);
`ifdef MEM_BOUND_CHECK_EN
        return (a >> 3) >= 64'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    // Model one completed access: returns the pre-write word and fault, applies the write.
    task automatic ref_access(input logic [63:0] a, input bit we, input logic [63:0] wd,
                              input logic [7:0] wm, output logic [63:0] exp_rd, output logic exp_flt);
        int unsigned idx;
        idx = int'((a >> 3) % 64'(DEPTH));
        exp_flt = ref_oob(a);
        exp_rd  = exp_flt ? 64'd0 : ref_mem[idx];
        if (we && !exp_flt) begin
            for (int b = 0; b < 8; b++)
                if (wm[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // Drive a request from a negedge and wait (bounded) for the completion pulse.
    task automatic run_req(input logic [63:0] a, input bit re, input bit we, input logic [63:0] wd,
                           input logic [7:0] wm, output int cyc, output logic [63:0] rd, output logic flt);
        address = a; re_mem = re; we_mem = we; wdata_mem = wd; wmask_mem = wm;
        cyc = -1; rd = '0; flt = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (mem_rvalid) begin
                cyc = n; rd = rdata_mem; flt = mem_fault;
                break;
            end
        end
        re_mem = 1'b0; we_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdata_mem !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata_mem); end
        checks++; if (mem_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", mem_rvalid); end
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
        checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", mem_fault); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; logic [63:0] rd, er; logic flt, ef;
        run_req(64'h28, 1'b0, 1'b1, 64'h1122334455667788, 8'hFF, cyc, rd, flt);
        ref_access(64'h28, 1'b1, 64'h1122334455667788, 8'hFF, er, ef);
        checks++; if (cyc !== LAT + 1) begin failures++; $display("FAIL basic_wr_latency got=%0d exp=%0d", cyc, LAT + 1); end
        checks++; if (rd !== er) begin failures++; $display("FAIL basic_wr_old got=%h exp=%h", rd, er); end
        @(negedge clk);
        checks++; if (mem_rvalid !== 1'b0) begin failures++; $display("FAIL basic_single_pulse got=%b exp=0", mem_rvalid); end
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%b exp=0", mem_busy); end
        run_req(64'h28, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h28, 1'b0, '0, '0, er, ef);
        checks++; if (cyc !== LAT + 1) begin failures++; $display("FAIL basic_rd_latency got=%0d exp=%0d", cyc, LAT + 1); end
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL basic_rd_data got=%h exp=1122334455667788", rd); end
        checks++; if (flt !== 1'b0) begin failures++; $display("FAIL basic_rd_fault got=%b exp=0", flt); end
        @(negedge clk);
        run_req(64'h28, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, cyc, rd, flt);
        ref_access(64'h28, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, er, ef);
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL mask_wr_old got=%h exp=1122334455667788", rd); end
        @(negedge clk);
        run_req(64'h2D, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h2D, 1'b0, '0, '0, er, ef);
        checks++; if (rd !== 64'h11223344FFFFFFFF) begin failures++; $display("FAIL mask_rd_data got=%h exp=11223344ffffffff", rd); end
        @(negedge clk);
    endtask

    task automatic test_walk();
        logic [63:0] addrs [4];
        int cyc; logic [63:0] rd, er; logic flt, ef;
        addrs = '{64'h100, 64'h208, 64'h310, 64'h28};
        for (int i = 0; i < 3; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            run_req(addrs[i], 1'b0, 1'b1, d, 8'hFF, cyc, rd, flt);
            ref_access(addrs[i], 1'b1, d, 8'hFF, er, ef);
            checks++; if (cyc !== ((i == 0) ? LAT + 1 : LAT + 2)) begin failures++; $display("FAIL b2b_wr_latency[%0d] got=%0d", i, cyc); end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            run_req(addrs[i], 1'b1, 1'b0, '0, '0, cyc, rd, flt);
            re_mem = 1'b1;
            ref_access(addrs[i], 1'b0, '0, '0, er, ef);
            checks++; if (cyc !== ((i == 0) ? LAT + 1 : LAT + 2)) begin failures++; $display("FAIL walk_period[%0d] got=%0d exp=%0d", i, cyc, (i == 0) ? LAT + 1 : LAT + 2); end
            checks++; if (rd !== er) begin failures++; $display("FAIL walk_data[%0d] got=%h exp=%h", i, rd, er); end
        end
        re_mem = 1'b0;
        @(negedge clk);
        checks++; if (mem_rvalid !== 1'b0 || mem_busy !== 1'b0) begin failures++; $display("FAIL walk_end got=%b%b exp=00", mem_rvalid, mem_busy); end
    endtask

    task automatic test_random();
        int cyc, exp_cyc; logic [63:0] rd, er, a, d; logic flt, ef; logic [7:0] m;
        int op; bit b2b;
        b2b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0 || !b2b) begin
                @(negedge clk);
                b2b = 1'b0;
            end
            a = 64'($urandom_range(0, 31)) * 8 + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a[63:16] = {$urandom, 16'($urandom)};
            d = {$urandom, $urandom};
            m = 8'($urandom);
            op = $urandom_range(0, 2);
            exp_cyc = b2b ? LAT + 2 : LAT + 1;
            run_req(a, op != 1, op != 0, d, m, cyc, rd, flt);
            ref_access(a, op != 0, d, m, er, ef);
            checks++; if (cyc !== exp_cyc) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, cyc, exp_cyc); end
            checks++; if (rd !== er) begin failures++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", i, a, rd, er); end
            checks++; if (flt !== ef) begin failures++; $display("FAIL rand_fault[%0d] got=%b exp=%b", i, flt, ef); end
            b2b = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int cyc; logic [63:0] rd, er, last; logic flt, ef;
        run_req(64'h40, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h40, 1'b0, '0, '0, last, ef);
        @(negedge clk);
        for (int v = 0; v < 2; v++) begin
            address = 64'h40; we_mem = 1'b1; wdata_mem = {$urandom, $urandom} ^ 64'hA5A5; wmask_mem = 8'hFF;
            repeat ((v == 0) ? 1 : LAT) @(negedge clk);
            checks++; if (mem_busy !== 1'b1 || mem_rvalid !== 1'b0) begin failures++; $display("FAIL flush_pre_busy[%0d] got=%b%b exp=10", v, mem_busy, mem_rvalid); end
            flush = 1'b1; we_mem = 1'b0;
            @(negedge clk);
            flush = 1'b0;
            checks++; if (mem_busy !== 1'b0 || mem_rvalid !== 1'b0) begin failures++; $display("FAIL flush_idle[%0d] got=%b%b exp=00", v, mem_busy, mem_rvalid); end
            checks++; if (rdata_mem !== last) begin failures++; $display("FAIL flush_rdata_hold[%0d] got=%h exp=%h", v, rdata_mem, last); end
            @(negedge clk);
            checks++; if (mem_rvalid !== 1'b0) begin failures++; $display("FAIL flush_no_pulse[%0d] got=%b exp=0", v, mem_rvalid); end
        end
        flush = 1'b1; re_mem = 1'b1; address = 64'h40;
        @(negedge clk);
        checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL flush_beats_capture got=%b exp=0", mem_busy); end
        flush = 1'b0; re_mem = 1'b0;
        @(negedge clk);
        run_req(64'h40, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h40, 1'b0, '0, '0, er, ef);
        checks++; if (rd !== er) begin failures++; $display("FAIL flush_array_kept got=%h exp=%h", rd, er); end
        @(negedge clk);
    endtask

    task automatic test_rst_busy();
        int cyc; logic [63:0] rd, er; logic flt, ef;
        address = 64'h28; we_mem = 1'b1; wdata_mem = 64'hDEAD_BEEF_0000_1234; wmask_mem = 8'hFF;
        repeat (LAT) @(negedge clk);
        rst = 1'b1; we_mem = 1'b0;
        @(negedge clk);
        checks++; if (rdata_mem !== 64'd0) begin failures++; $display("FAIL rst_busy_rdata got=%h exp=0", rdata_mem); end
        checks++; if ({mem_rvalid, mem_busy, mem_fault} !== 3'b000) begin failures++; $display("FAIL rst_busy_flags got=%b exp=000", {mem_rvalid, mem_busy, mem_fault}); end
        rst = 1'b0;
        @(negedge clk);
        run_req(64'h28, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h28, 1'b0, '0, '0, er, ef);
        checks++; if (rd !== er) begin failures++; $display("FAIL rst_array_kept got=%h exp=%h", rd, er); end
        @(negedge clk);
    endtask

    task automatic test_bound();
        int cyc; logic [63:0] rd, er; logic flt, ef;
        run_req(64'h8000, 1'b0, 1'b1, 64'hCAFE_F00D_1357_9BDF, 8'hFF, cyc, rd, flt);
        ref_access(64'h8000, 1'b1, 64'hCAFE_F00D_1357_9BDF, 8'hFF, er, ef);
        checks++; if (cyc !== LAT + 1) begin failures++; $display("FAIL bound_wr_latency got=%0d exp=%0d", cyc, LAT + 1); end
        checks++; if (flt !== ef) begin failures++; $display("FAIL bound_wr_fault got=%b exp=%b", flt, ef); end
        @(negedge clk);
        run_req(64'h8000, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h8000, 1'b0, '0, '0, er, ef);
        checks++; if (rd !== er) begin failures++; $display("FAIL bound_rd_data got=%h exp=%h", rd, er); end
        checks++; if (flt !== ef) begin failures++; $display("FAIL bound_rd_fault got=%b exp=%b", flt, ef); end
        @(negedge clk);
        checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL bound_fault_cleared got=%b exp=0", mem_fault); end
        run_req(64'h0, 1'b1, 1'b0, '0, '0, cyc, rd, flt);
        ref_access(64'h0, 1'b0, '0, '0, er, ef);
        checks++; if (rd !== er) begin failures++; $display("FAIL bound_word0 got=%h exp=%h", rd, er); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        test_reset();
        test_basic();
        test_walk();
        test_random();
        test_flush();
        test_rst_busy();
        test_bound();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
